// File: rtl/avalon_pkg.sv
// Shared types and constants for the Avalon-MM master bridge.
package avalon_pkg;

    localparam int DATA_W = 32;
    // Command address field is sized for the widest supported bus; unused upper bits stay zero.
    localparam int CMD_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } state_t;

    typedef struct packed {
        logic                  write;
        logic [CMD_ADDR_W-1:0] address;
        logic [DATA_W-1:0]     data;
    } cmd_t;

endpackage

// File: rtl/avalon_master_bridge_if.sv
// Command/response and Avalon-MM signals of the bridge, bundled with bridge-side and environment-side views.
interface avalon_master_bridge_if #(
    parameter int ADDRESSWIDTH = 4
);
    import avalon_pkg::*;

    // cmd: a command transfers on a rising edge where cmd_valid and cmd_ready are both 1;
    // cmd_valid seen while cmd_ready=0 is dropped, not queued. rsp: rsp_valid is a one-cycle
    // pulse with no backpressure, rsp_data/rsp_error qualified by it.
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_write;
    logic [ADDRESSWIDTH-1:0] cmd_address;
    logic [DATA_W-1:0]       cmd_data;
    logic                    rsp_valid;
    logic [DATA_W-1:0]       rsp_data;
    logic                    rsp_error;
    logic                    avm_read;
    logic                    avm_write;
    logic [ADDRESSWIDTH-1:0] avm_address;
    logic [DATA_W-1:0]       avm_writedata;
    logic                    avm_waitrequest;
    logic                    avm_readdatavalid;
    logic [DATA_W-1:0]       avm_readdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_address, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_error,
        output avm_read, avm_write, avm_address, avm_writedata,
        input  avm_waitrequest, avm_readdatavalid, avm_readdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_address, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_error,
        input  avm_read, avm_write, avm_address, avm_writedata,
        output avm_waitrequest, avm_readdatavalid, avm_readdata
    );

endinterface

// File: rtl/avalon_master_bridge.sv
// Single-outstanding Avalon-MM initiator: one command in, one Avalon transfer out, one response pulse back.
// All outputs are registered from the next-state decode; a watchdog bounds time spent in REQ/WAIT_RD.
module avalon_master_bridge
    import avalon_pkg::*;
#(
    parameter int ADDRESSWIDTH = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    avalon_master_bridge_if.master        bus,
    output state_t                        state_dbg
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);

    state_t            state, state_nxt;
    cmd_t              cmd_q, cmd_nxt;
    logic [TW-1:0]     timer, timer_nxt, timer_inc;
    logic [DATA_W-1:0] rsp_data_nxt;
    logic              rsp_error_nxt;
    logic              timeout_hit;

    // The watchdog fires in the cycle in which the timer would reach TIMEOUT, so a stuck
    // slave sees exactly TIMEOUT strobe cycles; it outranks waitrequest=0 / readdatavalid.
    always_comb begin
        timeout_hit = (TIMEOUT > 0) && (timer == TMO_LAST);
        timer_inc   = (timer == TMO_MAX) ? timer : timer + TW'(1);
    end

    always_comb begin
        state_nxt     = state;
        cmd_nxt       = cmd_q;
        timer_nxt     = timer;
        rsp_data_nxt  = '0;
        rsp_error_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    cmd_nxt.write   = bus.cmd_write;
                    cmd_nxt.address = CMD_ADDR_W'(bus.cmd_address);
                    cmd_nxt.data    = bus.cmd_data;
                    timer_nxt       = '0;
                    state_nxt       = REQ;
                end
            end
            REQ: begin
                if (timeout_hit) begin
                    timer_nxt     = timer_inc;
                    rsp_error_nxt = 1'b1;
                    state_nxt     = RESP;
                end else if (bus.avm_waitrequest) begin
                    timer_nxt = timer_inc;
                end else if (cmd_q.write) begin
                    state_nxt = RESP;
                end else begin
                    timer_nxt = '0;
                    state_nxt = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (timeout_hit) begin
                    timer_nxt     = timer_inc;
                    rsp_error_nxt = 1'b1;
                    state_nxt     = RESP;
                end else if (bus.avm_readdatavalid) begin
                    rsp_data_nxt = bus.avm_readdata;
                    state_nxt    = RESP;
                end else begin
                    timer_nxt = timer_inc;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            cmd_q             <= '0;
            timer             <= '0;
            bus.cmd_ready     <= 1'b0;
            bus.rsp_valid     <= 1'b0;
            bus.rsp_data      <= '0;
            bus.rsp_error     <= 1'b0;
            bus.avm_read      <= 1'b0;
            bus.avm_write     <= 1'b0;
            bus.avm_address   <= '0;
            bus.avm_writedata <= '0;
        end else begin
            state             <= state_nxt;
            cmd_q             <= cmd_nxt;
            timer             <= timer_nxt;
            bus.cmd_ready     <= (state_nxt == IDLE);
            bus.rsp_valid     <= (state_nxt == RESP);
            bus.rsp_data      <= rsp_data_nxt;
            bus.rsp_error     <= rsp_error_nxt;
            bus.avm_read      <= (state_nxt == REQ) && !cmd_nxt.write;
            bus.avm_write     <= (state_nxt == REQ) && cmd_nxt.write;
            bus.avm_address   <= (state_nxt == REQ) ? cmd_nxt.address[ADDRESSWIDTH-1:0] : '0;
            bus.avm_writedata <= ((state_nxt == REQ) && cmd_nxt.write) ? cmd_nxt.data : '0;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_avalon_master_bridge.sv
// Self-checking bench for avalon_master_bridge: directed scenarios plus a short random run,
// responses checked against an expected queue of {error, data}.
module tb_avalon_master_bridge;
    import avalon_pkg::*;

    localparam int AW  = 4;
    localparam int TMO = 8;

    logic   clk   = 1'b0;
    logic   reset = 1'b1;
    state_t state_dbg;
    int     checks = 0;
    int     errors = 0;

    logic [DATA_W:0] exp_q[$];
    logic [DATA_W:0] exp_v;
    logic            rsp_prev;

    avalon_master_bridge_if #(.ADDRESSWIDTH(AW)) bus ();

    avalon_master_bridge #(.ADDRESSWIDTH(AW), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL sim_timeout: simulation did not finish in time");
        $fatal(1, "simulation watchdog expired");
    end

    // response scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            rsp_prev <= 1'b0;
        end else begin
            if (bus.rsp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got rsp_valid error=%b data=%h, expected no response",
                             bus.rsp_error, bus.rsp_data);
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({bus.rsp_error, bus.rsp_data} !== exp_v) begin
                        errors++;
                        $display("FAIL rsp_payload: got error=%b data=%h, expected error=%b data=%h",
                                 bus.rsp_error, bus.rsp_data, exp_v[DATA_W], exp_v[DATA_W-1:0]);
                    end
                end
                checks++;
                if (rsp_prev) begin
                    errors++;
                    $display("FAIL rsp_pulse: rsp_valid high for more than one cycle");
                end
            end
            rsp_prev <= bus.rsp_valid;
        end
    end

    // drivers
    task automatic idle_inputs();
        bus.cmd_valid         = 1'b0;
        bus.cmd_write         = 1'b0;
        bus.cmd_address       = '0;
        bus.cmd_data          = '0;
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata      = '0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.cmd_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: cmd_ready=%b after 50 cycles, expected 1", bus.cmd_ready);
        end
    endtask

    // Called just after a negedge with cmd_ready=1; returns at the negedge of the first REQ cycle.
    task automatic drive_cmd(input logic w, input logic [AW-1:0] a, input logic [31:0] d);
        bus.cmd_valid   = 1'b1;
        bus.cmd_write   = w;
        bus.cmd_address = a;
        bus.cmd_data    = d;
        @(negedge clk);
        bus.cmd_valid   = 1'b0;
        bus.cmd_write   = 1'($urandom_range(0, 1));
        bus.cmd_address = AW'($urandom_range(0, 15));
        bus.cmd_data    = $urandom;
    endtask

    task automatic run_txn(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                           input int stall, input int lat, input logic [31:0] rd);
        wait_ready();
        exp_q.push_back(w ? {1'b0, 32'h0} : {1'b0, rd});
        bus.avm_waitrequest = (stall > 0);
        drive_cmd(w, a, d);
        for (int i = 0; i <= stall; i++) begin
            if (i == stall) bus.avm_waitrequest = 1'b0;
            checks++;
            if (bus.avm_read !== ~w || bus.avm_write !== w || bus.avm_address !== a ||
                (w && bus.avm_writedata !== d)) begin
                errors++;
                $display("FAIL txn_strobe cycle %0d: got rd=%b wr=%b addr=%h wdata=%h, expected rd=%b wr=%b addr=%h wdata=%h",
                         i, bus.avm_read, bus.avm_write, bus.avm_address, bus.avm_writedata, ~w, w, a, d);
            end
            @(negedge clk);
        end
        if (!w) begin
            checks++;
            if (bus.avm_read !== 1'b0 || state_dbg !== WAIT_RD) begin
                errors++;
                $display("FAIL txn_wait_rd: got avm_read=%b state=%0d, expected 0 and WAIT_RD",
                         bus.avm_read, state_dbg);
            end
            for (int i = 1; i < lat; i++) @(negedge clk);
            bus.avm_readdatavalid = 1'b1;
            bus.avm_readdata      = rd;
            @(negedge clk);
            bus.avm_readdatavalid = 1'b0;
            bus.avm_readdata      = $urandom;
        end
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.avm_read !== 1'b0 || bus.avm_write !== 1'b0) begin
            errors++;
            $display("FAIL txn_rsp_latency: got rsp_valid=%b rd=%b wr=%b, expected 1 0 0",
                     bus.rsp_valid, bus.avm_read, bus.avm_write);
        end
    endtask

    // scenarios
    task automatic test_reset();
        #2 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.cmd_valid         = 1'($urandom_range(0, 1));
            bus.cmd_write         = 1'($urandom_range(0, 1));
            bus.cmd_address       = AW'($urandom_range(0, 15));
            bus.cmd_data          = $urandom;
            bus.avm_waitrequest   = 1'($urandom_range(0, 1));
            bus.avm_readdatavalid = 1'($urandom_range(0, 1));
            bus.avm_readdata      = $urandom;
            #1;
            checks++;
            if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_error, bus.avm_read, bus.avm_write,
                 bus.avm_address, bus.avm_writedata, state_dbg} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got ready=%b rspv=%b rd=%b wr=%b addr=%h state=%0d, expected all 0",
                         bus.cmd_ready, bus.rsp_valid, bus.avm_read, bus.avm_write, bus.avm_address, state_dbg);
            end
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1 || state_dbg !== IDLE) begin
            errors++;
            $display("FAIL reset_release: got cmd_ready=%b state=%0d, expected 1 IDLE", bus.cmd_ready, state_dbg);
        end
    endtask

    task automatic test_write();
        run_txn(1'b1, 4'd3, 32'hA5A5_0001, 0, 0, 32'h0);
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.avm_write !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL write_ready_back: got ready=%b wr=%b rspv=%b, expected 1 0 0",
                     bus.cmd_ready, bus.avm_write, bus.rsp_valid);
        end
    endtask

    task automatic test_read_zero_wait();
        run_txn(1'b0, 4'd9, 32'h0, 0, 1, 32'hCAFE_0009);
    endtask

    task automatic test_stalled_read();
        run_txn(1'b0, 4'd2, 32'h0, 3, 2, 32'h1234_5678);
    endtask

    task automatic test_timeout_write();
        int cnt = 0;
        wait_ready();
        exp_q.push_back({1'b1, 32'h0});
        bus.avm_waitrequest = 1'b1;
        drive_cmd(1'b1, 4'd4, 32'h0000_BEEF);
        for (int i = 0; i < 30; i++) begin
            if (bus.avm_write !== 1'b1) break;
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != TMO || bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL timeout_write: got %0d strobe cycles rsp_valid=%b, expected %0d and 1",
                     cnt, bus.rsp_valid, TMO);
        end
        bus.avm_waitrequest = 1'b0;
    endtask

    task automatic test_timeout_read();
        wait_ready();
        exp_q.push_back({1'b1, 32'h0});
        bus.avm_waitrequest = 1'b0;
        drive_cmd(1'b0, 4'd6, 32'h0);
        @(negedge clk);
        for (int k = 1; k <= TMO; k++) begin
            checks++;
            if (bus.avm_read !== 1'b0 || bus.rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL timeout_read_wait %0d: got rd=%b rspv=%b, expected 0 0", k, bus.avm_read, bus.rsp_valid);
            end
            // data arriving in the expiry cycle must lose to the watchdog
            if (k == TMO) begin
                bus.avm_readdatavalid = 1'b1;
                bus.avm_readdata      = 32'hDEAD_BEEF;
            end
            @(negedge clk);
        end
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL timeout_read_rsp: got rsp_valid=%b, expected 1", bus.rsp_valid);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.avm_readdatavalid = 1'b0;
            checks++;
            if (bus.rsp_valid !== 1'b0 || state_dbg !== IDLE) begin
                errors++;
                $display("FAIL late_rdv_ignored: got rsp_valid=%b state=%0d, expected 0 IDLE", bus.rsp_valid, state_dbg);
            end
        end
    endtask

    task automatic test_busy();
        wait_ready();
        exp_q.push_back({1'b0, 32'h0BAD_F00D});
        exp_q.push_back({1'b0, 32'h0});
        bus.avm_waitrequest = 1'b0;
        bus.cmd_valid       = 1'b1;
        bus.cmd_write       = 1'b0;
        bus.cmd_address     = 4'd1;
        @(negedge clk);
        checks++;
        if (bus.avm_read !== 1'b1 || bus.avm_address !== 4'd1) begin
            errors++;
            $display("FAIL busy_first: got rd=%b addr=%h, expected 1 1", bus.avm_read, bus.avm_address);
        end
        bus.cmd_write   = 1'b1;
        bus.cmd_address = 4'd5;
        bus.cmd_data    = 32'h5555_AAAA;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.avm_readdatavalid = (i == 1);
            bus.avm_readdata      = 32'h0BAD_F00D;
            checks++;
            if (bus.avm_write !== 1'b0 || bus.cmd_ready !== (i == 3) || bus.rsp_valid !== (i == 2)) begin
                errors++;
                $display("FAIL busy_hold %0d: got wr=%b ready=%b rspv=%b, expected 0 %b %b",
                         i, bus.avm_write, bus.cmd_ready, bus.rsp_valid, (i == 3), (i == 2));
            end
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.avm_write !== 1'b1 || bus.avm_address !== 4'd5 || bus.avm_writedata !== 32'h5555_AAAA) begin
            errors++;
            $display("FAIL busy_second: got wr=%b addr=%h wdata=%h, expected 1 5 5555aaaa",
                     bus.avm_write, bus.avm_address, bus.avm_writedata);
        end
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL busy_second_rsp: got rsp_valid=%b, expected 1", bus.rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        wait_ready();
        bus.avm_waitrequest = 1'b1;
        drive_cmd(1'b0, 4'd9, 32'h0);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus.avm_read !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b0 || state_dbg !== IDLE) begin
            errors++;
            $display("FAIL reset_in_req: got rd=%b rspv=%b ready=%b state=%0d, expected 0 0 0 IDLE",
                     bus.avm_read, bus.rsp_valid, bus.cmd_ready, state_dbg);
        end
        @(negedge clk);
        bus.avm_waitrequest = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        wait_ready();
        drive_cmd(1'b0, 4'd2, 32'h0);
        @(negedge clk);
        checks++;
        if (state_dbg !== WAIT_RD) begin
            errors++;
            $display("FAIL reset_setup: got state=%0d, expected WAIT_RD", state_dbg);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus.avm_read !== 1'b0 || bus.rsp_valid !== 1'b0 || state_dbg !== IDLE) begin
            errors++;
            $display("FAIL reset_in_wait_rd: got rd=%b rspv=%b state=%0d, expected 0 0 IDLE",
                     bus.avm_read, bus.rsp_valid, state_dbg);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_recover: got ready=%b rspv=%b, expected 1 0", bus.cmd_ready, bus.rsp_valid);
        end
        run_txn(1'b1, 4'd7, 32'h7777_0007, 1, 0, 32'h0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            run_txn(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
                    $urandom_range(0, 3), $urandom_range(1, 3), $urandom);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_write();
        test_read_zero_wait();
        test_stalled_read();
        test_timeout_write();
        test_timeout_read();
        test_busy();
        test_reset_mid();
        test_back_to_back();
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
